// File: rtl/param_accum_computer_if.sv
// I/O handshake bundle of the accumulator computer: input word with valid/ready,
// output register with a one-cycle valid pulse.
interface param_accum_computer_if #(
  parameter int DATA_W = 4
) ();
  logic [DATA_W-1:0] InData;
  logic              InValid;
  logic              InReady;
  logic [DATA_W-1:0] OutData;
  logic              OutValid;

  // master: the environment that supplies input words and consumes output words
  modport master (
    output InData,
    output InValid,
    input  InReady,
    input  OutData,
    input  OutValid
  );

  // slave: the CPU core
  modport slave (
    input  InData,
    input  InValid,
    output InReady,
    output OutData,
    output OutValid
  );
endinterface

// File: rtl/param_accum_computer.sv
// Parametrised accumulator CPU: loadable program RAM, data RAM, carry/zero flags,
// conditional branches and valid/ready I/O, sequenced by a FETCH/EXEC/WAIT_IN/HALT FSM.
module param_accum_computer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                 CLK,
  input  logic                 ResetN,
  input  logic                 Run,
  input  logic                 PRAMWrite,
  input  logic [ADDR_W-1:0]    PRAMAddress,
  input  logic [ADDR_W+3:0]    PRAMData,
  param_accum_computer_if.slave io,
  output logic [ADDR_W-1:0]    PC,
  output logic                 Halted
);

  localparam int INSTR_W = 4 + ADDR_W;
  localparam int DEPTH   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_WAIT_IN,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_STO = 4'h3,
    OP_LDA = 4'h4,
    OP_B   = 4'h5,
    OP_BZ  = 4'h6,
    OP_BC  = 4'h7,
    OP_INP = 4'h8,
    OP_OUT = 4'h9,
    OP_LDI = 4'hA,
    OP_AND = 4'hB,
    OP_HLT = 4'hC
  } op_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                c_q, c_d;
  logic                z_q, z_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                outv_q, outv_d;
  logic                dram_we;

  logic [INSTR_W-1:0]  pram [DEPTH];
  logic [DATA_W-1:0]   dram [DEPTH];

  op_e                 op;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   mem_rd;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;

  assign op      = op_e'(ir_q[INSTR_W-1 -: 4]);
  assign operand = ir_q[ADDR_W-1:0];
  assign mem_rd  = dram[operand];
  assign sum     = {1'b0, acc_q} + {1'b0, mem_rd};
  // The extra top bit of the subtraction is the borrow, i.e. M > ACC.
  assign diff    = {1'b0, acc_q} - {1'b0, mem_rd};

  // Immediate: zero-extend the operand, or keep only its low DATA_W bits.
  always_comb begin
    imm = '0;
    for (int unsigned i = 0; i < DATA_W && i < ADDR_W; i++) begin
      imm[i] = operand[i];
    end
  end

  // Program RAM is written on any edge, independent of FSM state and reset.
  always_ff @(posedge CLK) begin
    if (PRAMWrite) begin
      pram[PRAMAddress] <= PRAMData;
    end
  end

  always_ff @(posedge CLK) begin
    if (ResetN && dram_we) begin
      dram[operand] <= acc_q;
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (Run) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op)
          OP_INP:  state_d = S_WAIT_IN;
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_WAIT_IN: begin
        if (io.InValid) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // FSM output / datapath next-state logic
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    out_d   = out_q;
    outv_d  = 1'b0;
    dram_we = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (Run) begin
          ir_d = pram[pc_q];
          pc_d = pc_q + ADDR_W'(1);
        end
      end
      S_EXEC: begin
        case (op)
          OP_ADD: begin
            {c_d, acc_d} = sum;
            z_d          = (sum[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            {c_d, acc_d} = diff;
            z_d          = (diff[DATA_W-1:0] == '0);
          end
          OP_STO: dram_we = 1'b1;
          OP_LDA: begin
            acc_d = mem_rd;
            z_d   = (mem_rd == '0);
          end
          OP_B: pc_d = operand;
          OP_BZ: begin
            if (z_q) begin
              pc_d = operand;
            end
          end
          OP_BC: begin
            if (c_q) begin
              pc_d = operand;
            end
          end
          OP_OUT: begin
            out_d  = acc_q;
            outv_d = 1'b1;
          end
          OP_LDI: begin
            acc_d = imm;
            z_d   = (imm == '0);
          end
          OP_AND: begin
            acc_d = acc_q & mem_rd;
            z_d   = ((acc_q & mem_rd) == '0);
          end
          default: ;
        endcase
      end
      S_WAIT_IN: begin
        if (io.InValid) begin
          acc_d = io.InData;
          z_d   = (io.InData == '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!ResetN) begin
      pc_q   <= '0;
      ir_q   <= '0;
      acc_q  <= '0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      out_q  <= '0;
      outv_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      acc_q  <= acc_d;
      c_q    <= c_d;
      z_q    <= z_d;
      out_q  <= out_d;
      outv_q <= outv_d;
    end
  end

  assign PC          = pc_q;
  assign Halted      = (state_q == S_HALT);
  assign io.InReady  = (state_q == S_WAIT_IN);
  assign io.OutData  = out_q;
  assign io.OutValid = outv_q;

  // An OUT is always followed by a FETCH, so the valid pulse never stretches.
  a_outvalid_pulse: assert property (@(posedge CLK) disable iff (!ResetN)
    io.OutValid |=> !io.OutValid);

endmodule

// File: tb/tb_param_accum_computer.sv
// Bench for param_accum_computer: an instruction-level interpreter predicts outputs,
// final PC and cycle counts for directed and random programs; a second 8/5 instance.
module tb_param_accum_computer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // default-width instance
  logic       a_rstn, a_run, a_pw, a_halt;
  logic [3:0] a_pa, a_pc;
  logic [7:0] a_pd;
  param_accum_computer_if #(.DATA_W(4)) ifa ();
  param_accum_computer #(.DATA_W(4), .ADDR_W(4)) u_a (
    .CLK(CLK), .ResetN(a_rstn), .Run(a_run), .PRAMWrite(a_pw),
    .PRAMAddress(a_pa), .PRAMData(a_pd), .io(ifa), .PC(a_pc), .Halted(a_halt)
  );

  // wide instance
  logic       b_rstn, b_run, b_pw, b_halt;
  logic [4:0] b_pa, b_pc;
  logic [8:0] b_pd;
  param_accum_computer_if #(.DATA_W(8)) ifb ();
  param_accum_computer #(.DATA_W(8), .ADDR_W(5)) u_b (
    .CLK(CLK), .ResetN(b_rstn), .Run(b_run), .PRAMWrite(b_pw),
    .PRAMAddress(b_pa), .PRAMData(b_pd), .io(ifb), .PC(b_pc), .Halted(b_halt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [7:0] prog_buf [16];
  int in_list[$];
  int mdram[16];
  int m_outs[$];
  int m_pc, m_steps;

  task automatic model_run(input int max_steps, output bit ok);
    int acc, c, z, pc, steps, ip, op, a, m;
    int d[16];
    d = mdram;
    m_outs.delete();
    acc = 0; c = 0; z = 0; pc = 0; steps = 0; ip = 0; ok = 0;
    while (steps < max_steps) begin
      op = int'(prog_buf[pc][7:4]);
      a  = int'(prog_buf[pc][3:0]);
      pc = (pc + 1) % 16;
      steps++;
      m = d[a];
      case (op)
        1:  begin acc = acc + m; c = (acc > 15) ? 1 : 0; acc = acc % 16; z = (acc == 0); end
        2:  begin c = (m > acc) ? 1 : 0; acc = (acc - m + 16) % 16; z = (acc == 0); end
        3:  d[a] = acc;
        4:  begin acc = m; z = (acc == 0); end
        5:  pc = a;
        6:  if (z != 0) pc = a;
        7:  if (c != 0) pc = a;
        8:  begin
              if (ip >= in_list.size()) return;
              acc = in_list[ip]; ip++; z = (acc == 0);
            end
        9:  m_outs.push_back(acc);
        10: begin acc = a; z = (acc == 0); end
        11: begin acc = acc & m; z = (acc == 0); end
        12: begin ok = 1; m_pc = pc; m_steps = steps; mdram = d; return; end
        default: ;
      endcase
    end
  endtask

  // ---------------- input driver and output comparator ----------------
  int  drv_q[$];
  int  exp_q[$];
  int  total_wait;
  int  drv_d;
  bit  drv_en = 0;
  bit  cmp_en = 0;

  initial begin
    forever begin
      @(negedge CLK);
      if (drv_en && ifa.InReady === 1'b1) begin
        drv_d = $urandom_range(0, 3);
        repeat (drv_d) @(negedge CLK);
        ifa.InData  = (drv_q.size() > 0) ? 4'(drv_q.pop_front()) : 4'd0;
        ifa.InValid = 1'b1;
        @(negedge CLK);
        ifa.InValid = 1'b0;
        total_wait += drv_d + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      if (ifa.OutValid !== 1'b0) begin
        if (exp_q.size() == 0) chk("unexpected OutValid", 32'(ifa.OutValid), 0);
        else chk("OutData", 32'(ifa.OutData), 32'(exp_q.pop_front()));
      end
      if (a_halt === 1'b1) chk("InReady while halted", 32'(ifa.InReady), 0);
    end
  end

  task automatic load_a();
    for (int i = 0; i < 16; i++) begin
      a_pw = 1'b1; a_pa = 4'(i); a_pd = prog_buf[i];
      @(negedge CLK);
    end
    a_pw = 1'b0;
  endtask

  task automatic reset_a();
    a_rstn = 1'b0;
    @(negedge CLK);
    a_rstn = 1'b1;
  endtask

  task automatic fill_prog(input logic [7:0] v);
    for (int i = 0; i < 16; i++) prog_buf[i] = v;
  endtask

  task automatic run_prog_a(input string tag, input int budget);
    int cyc;
    load_a();
    reset_a();
    exp_q = m_outs; drv_q = in_list; total_wait = 0;
    drv_en = 1; cmp_en = 1; a_run = 1'b1; cyc = 0;
    while (a_halt !== 1'b1 && cyc < budget) begin
      @(posedge CLK); cyc++;
      @(negedge CLK); #1;
    end
    chk({tag, " halted"}, 32'(a_halt), 1);
    chk({tag, " PC"}, 32'(a_pc), 32'(m_pc));
    chk({tag, " outputs missing"}, exp_q.size(), 0);
    chk({tag, " cycles"}, cyc, 2 * m_steps + total_wait);
    a_run = 1'b0; cmp_en = 0; drv_en = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  logic [8:0] bprog [32];
  int b_outs[$];
  int b_in[2];
  int b_idx, b_prev;
  bit ok, wrap;
  int v, cyc, tries;

  initial begin
    a_rstn = 1'b0; a_run = 1'b0; a_pw = 1'b0; a_pa = '0; a_pd = '0;
    ifa.InData = '0; ifa.InValid = 1'b0;
    b_rstn = 1'b0; b_run = 1'b0; b_pw = 1'b0; b_pa = '0; b_pd = '0;
    ifb.InData = '0; ifb.InValid = 1'b0;
    repeat (2) @(negedge CLK);

    // ---- wide instance: 200+100 wraps to 44 with carry, 1-200 borrows to 57, PC wraps
    for (int i = 0; i < 32; i++) bprog[i] = 9'h000;
    bprog[0]  = {4'h8, 5'd0};  bprog[1]  = {4'h3, 5'd3};  bprog[2]  = {4'h8, 5'd0};
    bprog[3]  = {4'h1, 5'd3};  bprog[4]  = {4'h7, 5'd6};  bprog[5]  = {4'hC, 5'd0};
    bprog[6]  = {4'h9, 5'd0};  bprog[7]  = {4'hA, 5'd1};  bprog[8]  = {4'h2, 5'd3};
    bprog[9]  = {4'h7, 5'd11}; bprog[10] = {4'hC, 5'd0};  bprog[11] = {4'h9, 5'd0};
    bprog[12] = {4'h5, 5'd31}; bprog[31] = {4'h0, 5'd0};
    for (int i = 0; i < 32; i++) begin
      b_pw = 1'b1; b_pa = 5'(i); b_pd = bprog[i];
      @(negedge CLK);
    end
    b_pw = 1'b0;
    b_rstn = 1'b1; b_run = 1'b1;
    b_in[0] = 200; b_in[1] = 100; b_idx = 0; b_prev = 0; wrap = 0;
    repeat (80) begin
      @(negedge CLK); #1;
      if (ifb.OutValid === 1'b1) b_outs.push_back(int'(ifb.OutData));
      if (b_prev == 31 && b_pc == 5'd0) wrap = 1;
      b_prev = int'(b_pc);
      if (ifb.InReady === 1'b1 && b_idx < 2 && !ifb.InValid) begin
        ifb.InData = 8'(b_in[b_idx]); ifb.InValid = 1'b1; b_idx++;
      end else begin
        ifb.InValid = 1'b0;
      end
    end
    chk("wide output count", b_outs.size(), 2);
    chk("wide ADD 200+100", (b_outs.size() > 0) ? b_outs[0] : -1, 44);
    chk("wide SUB 1-200", (b_outs.size() > 1) ? b_outs[1] : -1, 57);
    chk("wide PC wrap 31->0", 32'(wrap), 1);
    chk("wide waiting InReady", 32'(ifb.InReady), 1);
    chk("wide waiting PC", 32'(b_pc), 1);
    chk("wide not halted", 32'(b_halt), 0);
    b_run = 1'b0;

    // ---- data RAM initialisation through LDI/STO programs
    for (int base = 0; base < 16; base += 7) begin
      fill_prog(8'hC0);
      for (int k = 0; k < 7 && base + k < 16; k++) begin
        v = $urandom_range(0, 15);
        prog_buf[2*k]   = {4'hA, 4'(v)};
        prog_buf[2*k+1] = {4'h3, 4'(base + k)};
      end
      in_list.delete();
      model_run(100, ok);
      chk("init model halts", 32'(ok), 1);
      run_prog_a("init", 100);
    end

    // ---- carry branch, with literal pins on the model
    fill_prog(8'hC0);
    prog_buf[0] = 8'hA9; prog_buf[1] = 8'h30; prog_buf[2] = 8'hA8; prog_buf[3] = 8'h10;
    prog_buf[4] = 8'h77; prog_buf[5] = 8'h90; prog_buf[6] = 8'hC0; prog_buf[7] = 8'h90;
    prog_buf[8] = 8'hC0;
    in_list.delete();
    model_run(50, ok);
    chk("model carry ok", 32'(ok), 1);
    chk("model carry outs", m_outs.size(), 1);
    chk("model carry value", (m_outs.size() > 0) ? m_outs[0] : -1, 1);
    chk("model carry PC", m_pc, 9);
    chk("model carry steps", m_steps, 7);
    run_prog_a("carry", 100);
    a_run = 1'b1;
    repeat (5) @(negedge CLK);
    #1;
    chk("carry PC frozen", 32'(a_pc), 9);
    chk("carry still halted", 32'(a_halt), 1);
    a_run = 1'b0;

    // ---- sum loop, then reset in the middle of it
    fill_prog(8'h00);
    prog_buf[0] = 8'h80; prog_buf[1] = 8'h31; prog_buf[2] = 8'h80;
    prog_buf[3] = 8'h11; prog_buf[4] = 8'h90; prog_buf[5] = 8'h50;
    load_a();
    reset_a();
    exp_q = '{8, 7}; drv_q = '{6, 2, 3, 4}; total_wait = 0;
    drv_en = 1; cmp_en = 1; a_run = 1'b1; cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(negedge CLK); #1; cyc++;
    end
    chk("sum outputs seen", exp_q.size(), 0);
    drv_en = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("sum PC back to 0", 32'(a_pc), 0);
    repeat (2) @(negedge CLK);
    #1;
    chk("sum next INP InReady", 32'(ifa.InReady), 1);
    chk("sum next INP PC", 32'(a_pc), 1);
    cmp_en = 0;
    a_rstn = 1'b0;
    @(negedge CLK);
    a_rstn = 1'b1; a_run = 1'b0;
    #1;
    chk("reset PC", 32'(a_pc), 0);
    chk("reset OutData", 32'(ifa.OutData), 0);
    chk("reset OutValid", 32'(ifa.OutValid), 0);
    chk("reset InReady", 32'(ifa.InReady), 0);
    chk("reset Halted", 32'(a_halt), 0);
    mdram[1] = 3;

    // ---- input stall: Run=0 ignored while waiting; zero input drives BZ
    fill_prog(8'hC0);
    prog_buf[0] = 8'h80; prog_buf[1] = 8'h63; prog_buf[2] = 8'hC0;
    prog_buf[3] = 8'h90; prog_buf[4] = 8'hC0;
    load_a();
    reset_a();
    exp_q = '{0}; cmp_en = 1; a_run = 1'b1; cyc = 0;
    while (ifa.InReady !== 1'b1 && cyc < 10) begin
      @(negedge CLK); #1; cyc++;
    end
    chk("stall InReady reached", 32'(ifa.InReady), 1);
    a_run = 1'b0;
    repeat (10) begin
      @(negedge CLK); #1;
      chk("stall InReady held", 32'(ifa.InReady), 1);
      chk("stall PC frozen", 32'(a_pc), 1);
    end
    ifa.InData = 4'd0; ifa.InValid = 1'b1;
    @(negedge CLK);
    ifa.InValid = 1'b0; a_run = 1'b1; cyc = 0;
    while (a_halt !== 1'b1 && cyc < 20) begin
      @(negedge CLK); #1; cyc++;
    end
    chk("stall BZ halted", 32'(a_halt), 1);
    chk("stall BZ taken PC", 32'(a_pc), 5);
    chk("stall outputs seen", exp_q.size(), 0);
    cmp_en = 0; a_run = 1'b0;

    // ---- run gating with a program RAM patch while paused
    fill_prog(8'hC0);
    prog_buf[0] = 8'hA3; prog_buf[1] = 8'h90; prog_buf[2] = 8'hA4;
    prog_buf[3] = 8'h90; prog_buf[4] = 8'hC0;
    load_a();
    reset_a();
    exp_q = '{3, 9}; cmp_en = 1;
    repeat (20) begin
      @(negedge CLK); #1;
      chk("gated PC at 0", 32'(a_pc), 0);
      chk("gated OutValid low", 32'(ifa.OutValid), 0);
    end
    a_run = 1'b1; cyc = 0;
    while (exp_q.size() != 1 && cyc < 20) begin
      @(negedge CLK); #1; cyc++;
    end
    a_run = 1'b0;
    chk("gated first output", exp_q.size(), 1);
    a_pw = 1'b1; a_pa = 4'd2; a_pd = 8'hA9;
    repeat (20) begin
      @(negedge CLK); #1;
      a_pw = 1'b0;
      chk("paused PC", 32'(a_pc), 2);
      chk("paused OutData", 32'(ifa.OutData), 3);
    end
    a_run = 1'b1; cyc = 0;
    while (a_halt !== 1'b1 && cyc < 20) begin
      @(negedge CLK); #1; cyc++;
    end
    chk("gated halted", 32'(a_halt), 1);
    chk("gated final PC", 32'(a_pc), 5);
    chk("gated outputs seen", exp_q.size(), 0);
    cmp_en = 0; a_run = 1'b0;

    // ---- random programs against the interpreter
    for (int t = 0; t < 25; t++) begin
      tries = 0; ok = 0;
      while (!ok && tries < 50) begin
        for (int i = 0; i < 16; i++) prog_buf[i] = 8'($urandom_range(0, 255));
        prog_buf[15] = 8'hC0;
        in_list.delete();
        for (int i = 0; i < 16; i++) in_list.push_back($urandom_range(0, 15));
        model_run(150, ok);
        tries++;
      end
      if (ok) run_prog_a("random", 600);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_accum_computer.md
Name: param_accum_computer

Overview:
Parametrised successor to the 4-bit accumulator computer, with generic data width and address width. It has an on-chip program RAM that is loaded through a write port, and a separate data RAM. It adds carry and zero flags, conditional branches, subtract, load, immediate and halt instructions, and valid/ready handshakes on the input and output ports. It executes from program RAM under a run enable, as the top-level CPU of the teaching computer.

Parameters:
DATA_W, 4, accumulator / data RAM / I/O width
ADDR_W, 4, address and operand width; program RAM and data RAM each hold 2^ADDR_W words
INSTR_W, 4+ADDR_W, derived and not overridable; instruction = {opcode[3:0], operand[ADDR_W-1:0]}

Ports:
CLK  in  1  clock, all state on rising edge
ResetN  in  1  synchronous active-low reset
Run  in  1  1 = execute, 0 = stop at the next fetch
PRAMWrite  in  1  program RAM write strobe, sampled on CLK
PRAMAddress  in  ADDR_W  program RAM write address
PRAMData  in  INSTR_W  program RAM write data
InData  in  DATA_W  input word
InValid  in  1  InData valid
InReady  out  1  core waiting for input (INP)
OutData  out  DATA_W  output register
OutValid  out  1  one-cycle pulse when OutData is updated
PC  out  ADDR_W  program counter
Halted  out  1  core executed HLT

Behaviour:
- Clock and reset: one clock CLK; reset ResetN is synchronous and active-low.
- Reset values (ResetN=0 at an edge): PC=0, ACC=0, C=0, Z=0, IR=0, OutData=0, OutValid=0, InReady=0, Halted=0, state=FETCH.
  - Program RAM and data RAM are not cleared.
  - Reset overrides every state, including WAIT_IN and HALT.
- FSM states: FETCH, EXEC, WAIT_IN, HALT.
- FETCH:
  - If Run=1: IR <= PRAM[PC]; PC <= PC+1 (wraps 2^ADDR_W-1 -> 0); go to EXEC.
  - If Run=0: hold, with no state change.
- EXEC: executes IR, then goes to FETCH, except INP (goes to WAIT_IN) and HLT (goes to HALT). Every non-INP instruction takes 2 cycles. Let a = operand and M = DRAM[a]. Opcodes:
  - 0000 NOP.
  - 0001 ADD: {C,ACC} <= ACC+M.
  - 0010 SUB: ACC <= ACC-M mod 2^DATA_W; C <= 1 if M > ACC (borrow).
  - 0011 STO: DRAM[a] <= ACC.
  - 0100 LDA: ACC <= M.
  - 0101 B: PC <= a.
  - 0110 BZ: PC <= a if Z.
  - 0111 BC: PC <= a if C.
  - 1000 INP.
  - 1001 OUT: OutData <= ACC; OutValid=1 for exactly this one cycle.
  - 1010 LDI: ACC <= a, zero-extended, or truncated to the low DATA_W bits if ADDR_W > DATA_W.
  - 1011 AND: ACC <= ACC & M.
  - 1100 HLT.
  - 1101-1111: NOP.
- Flag updates:
  - Z <= (new ACC == 0) on ADD, SUB, LDA, LDI, AND and INP. Other instructions keep Z.
  - C changes only on ADD and SUB.
- WAIT_IN:
  - InReady=1, registered, asserted in the cycle after EXEC of INP.
  - On an edge with InValid=1: ACC <= InData, Z updated, InReady drops, go to FETCH.
  - InValid=0 holds indefinitely, with PC frozen.
- HALT: Halted=1 and the FSM is frozen; Run has no effect. Exit is by reset only.
- Run=0 is honoured only in FETCH. An instruction in EXEC or WAIT_IN completes first.
- Program RAM writes:
  - A write occurs whenever PRAMWrite=1 at an edge, in any state.
  - A fetch from the same address on the same edge returns the old contents.
  - Intended usage: load with Run=0.
- Data RAM: read is combinational on the operand; write is synchronous in EXEC.
- Branch targets use the full ADDR_W operand. The PC increment in FETCH is overridden by a taken branch in EXEC.

Test Plan:
1. Reset: ResetN=0 for 1 edge, while running mid-program -> next cycle PC=0, OutData=0, OutValid=0, InReady=0, Halted=0.
2. Sum loop:
   - Program: INP; STO 1; INP; ADD 1; OUT; B 0.
   - Stimulus: Run=1; InData 6 then 2, each presented with InValid when InReady=1.
   - Required: OutData=8 with one OutValid pulse; PC returns to 0; the next pair 3,4 gives OutData=7.
3. Carry branch:
   - Program: LDI 9; STO 0; LDI 8; ADD 0; BC 7; OUT; HLT; (7:) OUT; HLT.
   - Required: ACC=1, C=1, branch taken, a single OutValid with OutData=1, Halted=1, PC=9 frozen.
4. Input stall:
   - INP with InValid=0 for 10 cycles -> InReady=1 throughout, PC unchanged, Run=0 ignored.
   - InValid=1 with InData=0 -> ACC=0, Z=1; a following BZ is taken.
5. Run gating: Run=0 during FETCH -> PC and outputs constant for 20 cycles; Run=1 resumes at the same PC; PRAM writes at that time are fetched correctly.
6. DATA_W=8, ADDR_W=5:
   - INP 200; STO 3; INP 100; ADD 3; OUT -> OutData=44, C=1.
   - SUB with M > ACC sets C=1.
   - PC wraps 31 -> 0 on a NOP at address 31.
